ser2par: RTL and testbench

Serial-to-parallel word assembler, the inverse of the accelerator's parallel-to-serial unloader. It collects DWI-bit beats from a narrow stream (e.g. 32-bit bus or FIFO read side) and assembles them into one DWO-bit wide word (e.g. a 224-bit row or weight vector) for the compute array. Beat 0 lands in the LSB slice, matching the unloader, which emits the low slice first. A double buffer (assembly register plus output holding register) lets input keep streaming while the consumer stalls.

---
 rtl/acc_pkg.sv | 16 +
 rtl/ser2par.sv | 83 ++++++++
 tb/tb_ser2par.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// Widths and beat arithmetic shared by the accelerator's serial<->parallel converters.
package acc_pkg;

  localparam int DW_BUS = 32;
  localparam int DW_ROW = 224;

  function automatic int calc_beats(input int dwi, input int dwo);
    return dwo / dwi;
  endfunction

  // Counter width never drops below one bit, even for a single-beat word.
  function automatic int calc_cw(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction

endpackage

// File: rtl/ser2par.sv
// Assembles BEATS narrow beats (beat 0 in the LSB slice) into one wide word; word is valid 1 cycle after its last beat.
// Double-buffered: only the last beat stalls, and only while the held word is not taken (out_ready -> in_ready is combinational).
module ser2par
  import acc_pkg::*;
#(
  parameter int DWI = DW_BUS,
  parameter int DWO = DW_ROW,
  localparam int BEATS = calc_beats(DWI, DWO),
  localparam int CW = calc_cw(BEATS)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DWI-1:0] din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DWO-1:0] dout,
  output logic [CW-1:0]  beat_cnt
);

  if (DWO % DWI != 0) begin : g_width_chk
    $error("ser2par: DWO must be a multiple of DWI");
  end

  logic [DWO-1:0] asm_q, asm_d;
  logic [DWO-1:0] dout_q, dout_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           out_valid_q, out_valid_d;
  logic           last_beat;
  logic           accept;

  assign last_beat = (beat_cnt_q == CW'(BEATS - 1));
  assign in_ready  = !clr && !(last_beat && out_valid_q && !out_ready);
  assign accept    = in_valid && in_ready;

  always_comb begin
    asm_d       = asm_q;
    dout_d      = dout_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    if (clr) begin
      asm_d       = '0;
      beat_cnt_d  = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept) begin
        asm_d[int'(beat_cnt_q) * DWI +: DWI] = din;
        if (last_beat) begin
          // The freshly written slice completes the word, so take it from asm_d.
          beat_cnt_d  = '0;
          dout_d      = asm_d;
          out_valid_d = 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q       <= '0;
      dout_q      <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      asm_q       <= asm_d;
      dout_q      <= dout_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign beat_cnt  = beat_cnt_q;

endmodule

// File: tb/tb_ser2par.sv
// Self-checking bench for ser2par: vector table, directed corner sequences, and a randomized run against a queue-based model.
module tb_ser2par;

  localparam int BEATS = 7;

  logic         clk = 1'b0;
  logic         rst_n, clr, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]  din;
  logic [223:0] dout;
  logic [2:0]   beat_cnt;

  logic         p_clr, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [7:0]   p_din;
  logic [31:0]  p_dout;
  logic [1:0]   p_beat_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ser2par #(.DWI(32), .DWO(224)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .beat_cnt(beat_cnt)
  );

  ser2par #(.DWI(8), .DWO(32)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(p_clr),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .din(p_din),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .dout(p_dout),
    .beat_cnt(p_beat_cnt)
  );

  typedef struct {
    logic         vld;
    logic [31:0]  d;
    logic         ordy;
    logic         c;
    logic         e_rdy;
    logic         e_ovld;
    int           e_cnt;
    logic         chk_dout;
    logic [223:0] e_dout;
  } vec_t;

  vec_t tbl[9];

  logic [31:0]  part[$];
  logic         m_ov;
  logic [223:0] m_dout;

  task automatic chk(input string nm, input logic [223:0] act, input logic [223:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs on the falling edge; outputs are sampled 1 time unit later.
  task automatic step(input logic v, input logic [31:0] d, input logic r, input logic c);
    @(negedge clk);
    in_valid = v; din = d; out_ready = r; clr = c;
    #1;
  endtask

  task automatic pstep(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    p_in_valid = v; p_din = d; p_out_ready = r; p_clr = 1'b0;
    #1;
  endtask

  function automatic logic [223:0] word_from(input logic [31:0] first);
    logic [223:0] w = '0;
    for (int k = 0; k < BEATS; k++) w[k*32 +: 32] = first + 32'(k);
    return w;
  endfunction

  function automatic logic [223:0] assemble(input logic [31:0] q[$]);
    logic [223:0] w = '0;
    for (int k = 0; k < q.size(); k++) w = w | ({192'b0, q[k]} << (32 * k));
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [223:0] w0, w1, wa, wc;
    logic         v, r, c, e_rdy, e_ov;
    logic [31:0]  d;
    int           e_cnt;

    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    p_clr = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b0; p_din = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ovld", {223'b0, out_valid}, 224'd0);
    chk("rst_dout", dout, 224'd0);
    chk("rst_cnt", {221'b0, beat_cnt}, 224'd0);
    chk("rst_rdy", {223'b0, in_ready}, 224'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic word: beats 1..7 with the consumer always ready.
    w0 = word_from(32'h1);
    for (int i = 0; i < 7; i++)
      tbl[i] = '{vld: 1'b1, d: 32'(i + 1), ordy: 1'b1, c: 1'b0, e_rdy: 1'b1,
                 e_ovld: 1'b0, e_cnt: i, chk_dout: 1'b0, e_dout: '0};
    tbl[7] = '{vld: 1'b0, d: 32'h0, ordy: 1'b1, c: 1'b0, e_rdy: 1'b1,
               e_ovld: 1'b1, e_cnt: 0, chk_dout: 1'b1, e_dout: w0};
    tbl[8] = '{vld: 1'b0, d: 32'h0, ordy: 1'b0, c: 1'b0, e_rdy: 1'b1,
               e_ovld: 1'b0, e_cnt: 0, chk_dout: 1'b1, e_dout: w0};
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].vld, tbl[i].d, tbl[i].ordy, tbl[i].c);
      chk($sformatf("tbl%0d_rdy", i), {223'b0, in_ready}, {223'b0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_ovld", i), {223'b0, out_valid}, {223'b0, tbl[i].e_ovld});
      chk($sformatf("tbl%0d_cnt", i), {221'b0, beat_cnt}, 224'(tbl[i].e_cnt));
      if (tbl[i].chk_dout) chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
    end

    // Throughput: 21 back-to-back beats, one word every 7 cycles.
    for (int i = 0; i < 22; i++) begin
      step(i < 21, 32'h100 + 32'(i), 1'b1, 1'b0);
      e_ov = (i == 7) || (i == 14) || (i == 21);
      chk($sformatf("thr%0d_rdy", i), {223'b0, in_ready}, 224'd1);
      chk($sformatf("thr%0d_ovld", i), {223'b0, out_valid}, {223'b0, e_ov});
      chk($sformatf("thr%0d_cnt", i), {221'b0, beat_cnt}, 224'(i % 7));
      if (e_ov) chk($sformatf("thr%0d_dout", i), dout, word_from(32'h100 + 32'(i - 7)));
    end

    // Backpressure: consumer stalled, the 14th beat waits until out_ready rises.
    w0 = word_from(32'h200);
    w1 = word_from(32'h207);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 32'h200 + 32'((i < 13) ? i : 13), (i == 15), 1'b0);
      e_rdy = !((i == 13) || (i == 14));
      e_cnt = (i < 7) ? i : ((i < 14) ? i - 7 : 6);
      chk($sformatf("bp%0d_rdy", i), {223'b0, in_ready}, {223'b0, e_rdy});
      chk($sformatf("bp%0d_ovld", i), {223'b0, out_valid}, {223'b0, (i >= 7)});
      chk($sformatf("bp%0d_cnt", i), {221'b0, beat_cnt}, 224'(e_cnt));
      if (i >= 7) chk($sformatf("bp%0d_dout", i), dout, w0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_ovld_kept", {223'b0, out_valid}, 224'd1);
    chk("bp_dout_w1", dout, w1);
    chk("bp_cnt_wrap", {221'b0, beat_cnt}, 224'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp_drained", {223'b0, out_valid}, 224'd0);
    chk("bp_dout_hold", dout, w1);

    // clr mid-word: partial beats dropped, dout untouched, beats refused during clr.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h303, 1'b0, 1'b1);
    chk("clr_rdy", {223'b0, in_ready}, 224'd0);
    chk("clr_cnt_before", {221'b0, beat_cnt}, 224'd3);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("clr_cnt_after", {221'b0, beat_cnt}, 224'd0);
    chk("clr_ovld", {223'b0, out_valid}, 224'd0);
    chk("clr_dout_kept", dout, w1);
    wa = word_from(32'hA0);
    for (int i = 0; i < 7; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("clr_a_ovld", {223'b0, out_valid}, 224'd1);
    chk("clr_a_dout", dout, wa);

    // Async reset mid-word with a held output.
    step(1'b1, 32'hB0, 1'b0, 1'b0);
    step(1'b1, 32'hB1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ar_cnt_pre", {221'b0, beat_cnt}, 224'd2);
    chk("ar_ovld_pre", {223'b0, out_valid}, 224'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_ovld", {223'b0, out_valid}, 224'd0);
    chk("ar_dout", dout, 224'd0);
    chk("ar_cnt", {221'b0, beat_cnt}, 224'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wc = word_from(32'hC0);
    for (int i = 0; i < 7; i++) step(1'b1, 32'hC0 + 32'(i), 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("ar_new_ovld", {223'b0, out_valid}, 224'd1);
    chk("ar_new_dout", dout, wc);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("ar_new_drained", {223'b0, out_valid}, 224'd0);

    // Randomized traffic against the queue model.
    part.delete();
    m_ov = 1'b0;
    m_dout = wc;
    for (int n = 0; n < 3000; n++) begin
      v = ($urandom_range(0, 9) < 7);
      d = $urandom;
      r = $urandom_range(0, 1) == 1;
      c = ($urandom_range(0, 49) == 0);
      step(v, d, r, c);
      e_rdy = !c && !((part.size() == BEATS - 1) && m_ov && !r);
      chk($sformatf("rnd%0d_rdy", n), {223'b0, in_ready}, {223'b0, e_rdy});
      chk($sformatf("rnd%0d_ovld", n), {223'b0, out_valid}, {223'b0, m_ov});
      chk($sformatf("rnd%0d_cnt", n), {221'b0, beat_cnt}, 224'(part.size()));
      chk($sformatf("rnd%0d_dout", n), dout, m_dout);
      if (c) begin
        part.delete();
        m_ov = 1'b0;
      end else begin
        if (m_ov && r) m_ov = 1'b0;
        if (v && e_rdy) begin
          part.push_back(d);
          if (part.size() == BEATS) begin
            m_dout = assemble(part);
            part.delete();
            m_ov = 1'b1;
          end
        end
      end
    end

    // Narrow variant: four byte beats form one 32-bit word.
    for (int i = 0; i < 5; i++) begin
      pstep(i < 4, 8'(8'h11 * (i + 1)), 1'b1);
      chk($sformatf("p%0d_rdy", i), {223'b0, p_in_ready}, 224'd1);
      chk($sformatf("p%0d_cnt", i), {222'b0, p_beat_cnt}, 224'(i % 4));
      chk($sformatf("p%0d_ovld", i), {223'b0, p_out_valid}, {223'b0, (i == 4)});
    end
    chk("p_dout", {192'b0, p_dout}, {192'b0, 32'h44332211});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
